instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage that sits directly upstream of the single-cycle datapath. It holds the program counter and a writable instruction memory, then presents one instruction per cycle with a valid strobe, in place of the switch-selected instruction. It supports a free-run mode and a single-step mode for board use, stall and branch redirect from the datapath, a HALT sentinel, and a retired-instruction counter for probing.

## Interface
- DEPTH, 16: instruction memory words (power of two, ≥2); AW = $clog2(DEPTH)
- HALT_WORD, 32'hFFFF_FFFF: instruction word that stops fetch
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: leave LOAD/HALT, begin at PC 0
- run  in  1  sampled when start is accepted: 1 = free-run, 0 = step mode
- step  in  1  level from button; each rising edge requests one instruction in step mode
- stall  in  1  datapath hold: no advance, inst_valid=0
- branch_taken  in  1  redirect on the current valid instruction
- branch_target  in  32  byte address; bits [1:0] ignored
- prog_we  in  1  write instruction memory (LOAD state only)
- prog_addr  in  AW  word address for the write
- prog_data  in  32  word to write
- inst  out  32  current instruction; 32'h0 (NOP) when not fetching
- pc  out  32  byte address of inst, always word-aligned
- pc_plus4  out  32  pc + 4, mod 2^32
- inst_valid  out  1  inst must be executed/committed this cycle
- halted  out  1  state == HALT
- fetch_state  out  2  LOAD=0, RUN=1, STEP=2, HALT=3
- retired  out  16  count of cycles with inst_valid=1, saturates at 16'hFFFF

## Operation
- Memory: word-addressed array mem[DEPTH], read asynchronously at index pc[AW+1:2]; written synchronously when prog_we=1 in LOAD; reset does not clear it.
- The fetch word is the value mem[pc[AW+1:2]].
- LOAD: inst=0, inst_valid=0, pc held at 0. On start, go to RUN if run=1, otherwise go to STEP. pc is set to 0 and retired is cleared.
- RUN: inst = fetch word. inst_valid = ~stall & (fetch word ≠ HALT_WORD).
- STEP:
  - step is registered (step_d); step_rise = step & ~step_d.
  - A rise sets step_pending. Further rises while pending are absorbed.
  - inst = fetch word. inst_valid = step_pending & ~stall & (fetch word ≠ HALT_WORD).
  - step_pending clears on the edge where inst_valid=1.
- Next-PC when inst_valid=1, by priority:
  - branch_taken: {branch_target[31:2],2'b00}
  - otherwise: pc+4
- When inst_valid=0, pc holds. stall has priority over both branch and increment.
- HALT entry, at the next edge, from RUN or STEP:
  - the fetch word equals HALT_WORD (no valid is issued for it); or
  - next-PC word index ≥ DEPTH, meaning the target is outside memory or there is a fall-through past the last word. pc takes the offending value.
- HALT: inst=0, inst_valid=0, pc frozen.
  - start returns the block to RUN/STEP at pc 0, per run.
  - The block returns to LOAD only via rst.
- start in RUN/STEP is ignored. prog_we outside LOAD is ignored.
- retired increments on every inst_valid=1 cycle and saturates.

## Timing
- All outputs reset asynchronously on rst=0:
  - pc=0, pc_plus4=4, inst=0, inst_valid=0, halted=0, fetch_state=LOAD, retired=0
  - step_d=0, step_pending=0
- Reset mid-run takes effect immediately and abandons any pending step.
- inst, inst_valid and pc_plus4 are combinational from the registered state, pc and inputs. They settle in the same cycle.
- start accepted at edge N → fetch_state changes at N. inst_valid can be 1 in cycle N (RUN).
- Step latency:
  - step rise sampled at edge N sets pending.
  - inst_valid=1 during cycle N..N+1, if not stalled.
  - pc advances at edge N+1.
- Stall during a pending step holds the request until stall=0.
- pc wraps only mathematically. A word index ≥ DEPTH always forces HALT and is never read as an aliased address.

## Test plan
- Load {0x5400_0005, 0x5000_0002, HALT_WORD} at words 0..2. start with run=1 → inst_valid high for pc=0 and pc=4, pc=8 at the third edge, halted=1 next edge, retired=2.
- Same program, run=0: hold step low for 5 cycles → no valid, pc=0. Pulse step (one 3-cycle-high pulse) → exactly one valid cycle, pc=4, retired=1.
- RUN with stall=1 for cycles 2-4 → pc frozen at 8 and inst_valid=0 during the stall, then resumes to 12. A step rise while stalled in STEP mode is issued once, after stall drops.
- branch_taken=1 with branch_target=0x0000_0007 on valid at pc=4 → pc=4 next. With target 0x0000_0040 (DEPTH=16) → halted=1, pc=0x40, inst=0.
- Free-run with no HALT word in the last location → fall-through from pc=0x3C halts with pc=0x40. Assert rst mid-run → all outputs at reset values immediately and memory contents intact on reload-free restart.
- prog_we=1 during RUN → memory unchanged. start during RUN → ignored. Run 70000 valid cycles via branch loop → retired=16'hFFFF.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: program counter plus writable instruction memory feeding a
// single-cycle datapath. Supports free-run and single-step modes, stall,
// branch redirect, a HALT sentinel word and a saturating retired counter.
module instr_fetch #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          run,
    input  logic          step,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    output logic [31:0]   inst,
    output logic [31:0]   pc,
    output logic [31:0]   pc_plus4,
    output logic          inst_valid,
    output logic          halted,
    output logic [1:0]    fetch_state,
    output logic [15:0]   retired
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];
    logic        step_d;
    logic        step_pending;

    logic [31:0] fetch_word;
    logic        is_halt_word;
    logic        active;
    logic        step_rise;
    logic [31:0] next_pc;
    logic        next_oob;

    // Fetch path and next-PC selection; the word index of pc is always in
    // range while fetching because an out-of-range next-PC forces HALT.
    always_comb begin
        fetch_word   = mem[pc[AW+1:2]];
        is_halt_word = (fetch_word == HALT_WORD);
        active       = (state == RUN) || (state == STEP);
        step_rise    = step & ~step_d;
        inst_valid   = active & ~stall & ~is_halt_word &
                       ((state == RUN) | step_pending);
        inst         = active ? fetch_word : 32'h0;
        pc_plus4     = pc + 32'd4;
        next_pc      = branch_taken ? (branch_target & ~32'h3) : pc_plus4;
        next_oob     = |next_pc[31:AW+2];
    end

    assign halted      = (state == HALT);
    assign fetch_state = state;

    // Program memory: written only while loading, never cleared by reset.
    always_ff @(posedge clk) begin
        if (state == LOAD && prog_we)
            mem[prog_addr] <= prog_data;
    end

    // Fetch FSM, program counter, step handshake and retired counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= LOAD;
            pc           <= 32'h0;
            retired      <= 16'h0;
            step_d       <= 1'b0;
            step_pending <= 1'b0;
        end else begin
            step_d <= step;
            case (state)
                LOAD: begin
                    if (start) begin
                        state        <= run ? RUN : STEP;
                        pc           <= 32'h0;
                        retired      <= 16'h0;
                        step_pending <= 1'b0;
                    end
                end
                RUN, STEP: begin
                    if (is_halt_word) begin
                        // Sentinel reached: stop without issuing it.
                        state <= HALT;
                    end else if (inst_valid) begin
                        pc           <= next_pc;
                        step_pending <= 1'b0;
                        if (next_oob)
                            state <= HALT;
                        if (retired != 16'hFFFF)
                            retired <= retired + 16'd1;
                    end else if (state == STEP && step_rise) begin
                        // Extra rises while already pending are absorbed.
                        step_pending <= 1'b1;
                    end
                end
                HALT: begin
                    if (start) begin
                        state        <= run ? RUN : STEP;
                        pc           <= 32'h0;
                        step_pending <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// episodes, all compared every cycle against a behavioural model.
module tb_instr_fetch;

    localparam int          DEPTH = 16;
    localparam logic [31:0] HW    = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 0, run = 0, step = 0, stall = 0, branch_taken = 0;
    logic [31:0] branch_target = 0;
    logic        prog_we = 0;
    logic [3:0]  prog_addr = 0;
    logic [31:0] prog_data = 0;
    logic [31:0] inst, pc, pc_plus4;
    logic        inst_valid, halted;
    logic [1:0]  fetch_state;
    logic [15:0] retired;

    instr_fetch #(.DEPTH(DEPTH), .HALT_WORD(HW)) dut (
        .clk(clk), .rst(rst), .start(start), .run(run), .step(step),
        .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .inst(inst), .pc(pc),
        .pc_plus4(pc_plus4), .inst_valid(inst_valid), .halted(halted),
        .fetch_state(fetch_state), .retired(retired)
    );

    always #5 clk = ~clk;

    // Reference model: 0=LOAD 1=RUN 2=STEP 3=HALT
    logic [31:0] mm [DEPTH];
    int          m_st;
    logic [31:0] m_pc;
    int          m_ret;
    bit          m_pend, m_stepd;

    int checks = 0, passed = 0, vcount = 0;
    bit chk_en = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] m_fw();
        return (m_pc / 4 < DEPTH) ? mm[m_pc / 4] : 32'h0;
    endfunction

    function automatic bit m_active();
        return (m_st == 1) || (m_st == 2);
    endfunction

    function automatic bit m_valid();
        return m_active() && !stall && (m_fw() != HW) && (m_st == 1 || m_pend);
    endfunction

    task automatic check_outputs();
        chk("inst", inst, m_active() ? m_fw() : 32'h0);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("inst_valid", 32'(inst_valid), 32'(m_valid()));
        chk("halted", 32'(halted), 32'(m_st == 3));
        chk("fetch_state", 32'(fetch_state), 32'(m_st));
        chk("retired", 32'(retired), 32'(m_ret));
    endtask

    task automatic model_step();
        bit          v, rise;
        logic [31:0] fw, npc;
        v    = m_valid();
        rise = step && !m_stepd;
        fw   = m_fw();
        m_stepd = step;
        case (m_st)
            0: begin
                if (prog_we) mm[prog_addr] = prog_data;
                if (start) begin
                    m_st = run ? 1 : 2; m_pc = 0; m_ret = 0; m_pend = 0;
                end
            end
            1, 2: begin
                if (fw == HW) m_st = 3;
                else if (v) begin
                    npc  = branch_taken ? {branch_target[31:2], 2'b00} : m_pc + 32'd4;
                    m_pc = npc;
                    if (npc >= 4 * DEPTH) m_st = 3;
                    if (m_ret < 65535) m_ret++;
                    m_pend = 0;
                end else if (m_st == 2 && rise) m_pend = 1;
            end
            default: begin
                if (start) begin
                    m_st = run ? 1 : 2; m_pc = 0; m_pend = 0;
                end
            end
        endcase
    endtask

    // Called just after a rising edge; checks mid-cycle, then advances one edge.
    task automatic tick();
        #3;
        if (chk_en) check_outputs();
        if (inst_valid) vcount++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        m_st = 0; m_pc = 0; m_ret = 0; m_pend = 0; m_stepd = 0;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        prog_we = 1; prog_addr = 4'(a); prog_data = d;
        tick();
        prog_we = 0;
    endtask

    task automatic go(input bit r);
        start = 1; run = r;
        tick();
        start = 0;
    endtask

    initial begin
        // Reset values and program load
        do_reset();
        chk("rst_pc4", pc_plus4, 32'h4);
        load(0, 32'h5400_0005);
        load(1, 32'h5000_0002);
        load(2, HW);
        for (int i = 3; i < DEPTH; i++) load(i, 32'h0100_0000 + 32'(i));

        // Free-run into the HALT sentinel
        go(1);
        chk("t1_v0", 32'(inst_valid), 1);
        tick();
        chk("t1_pc4", pc, 32'h4);
        tick();
        chk("t1_pc8", pc, 32'h8);
        chk("t1_nv", 32'(inst_valid), 0);
        tick();
        chk("t1_halt", 32'(halted), 1);
        chk("t1_ret", 32'(retired), 2);

        // Step mode: one 3-cycle pulse gives exactly one instruction
        do_reset();
        go(0);
        repeat (5) tick();
        chk("t2_idle_pc", pc, 32'h0);
        vcount = 0;
        step = 1;
        repeat (3) tick();
        step = 0;
        repeat (3) tick();
        chk("t2_nvalid", 32'(vcount), 1);
        chk("t2_pc", pc, 32'h4);
        chk("t2_ret", 32'(retired), 1);

        // Stall in RUN freezes pc at 8
        do_reset();
        load(2, 32'h0100_0002);
        go(1);
        tick();
        tick();
        stall = 1;
        repeat (3) begin
            #1 chk("t3_stall_nv", 32'(inst_valid), 0);
            tick();
            chk("t3_stall_pc", pc, 32'h8);
        end
        stall = 0;
        tick();
        chk("t3_resume", pc, 32'hC);

        // Step rise while stalled is issued once after stall drops
        do_reset();
        go(0);
        stall = 1; step = 1;
        repeat (2) tick();
        step = 0;
        repeat (2) tick();
        chk("t3s_held", pc, 32'h0);
        stall = 0;
        vcount = 0;
        repeat (3) tick();
        chk("t3s_once", 32'(vcount), 1);
        chk("t3s_pc", pc, 32'h4);

        // Branch redirect, then branch out of memory
        do_reset();
        go(1);
        tick();
        branch_taken = 1; branch_target = 32'h7;
        tick();
        chk("t4_br", pc, 32'h4);
        branch_target = 32'h40;
        tick();
        branch_taken = 0;
        #1;
        chk("t4_oob_h", 32'(halted), 1);
        chk("t4_oob_pc", pc, 32'h40);
        chk("t4_oob_inst", inst, 32'h0);

        // Fall-through past the last word
        go(1);
        repeat (16) tick();
        chk("t5_fall_h", 32'(halted), 1);
        chk("t5_fall_pc", pc, 32'h40);

        // Reset mid-run, restart without reloading
        go(1);
        repeat (3) tick();
        do_reset();
        chk("t5_rst_state", 32'(fetch_state), 0);
        go(1);

        // Writes and start are ignored while running
        prog_we = 1; prog_addr = 4'd6; prog_data = 32'hDEAD_BEEF;
        tick();
        prog_we = 0;
        start = 1; run = 0;
        tick();
        start = 0;
        chk("t6_start_ign", 32'(fetch_state), 1);
        repeat (8) begin
            tick();
            if (pc == 32'h18) chk("t6_we_ign", inst, 32'h0100_0006);
        end

        // Retired counter saturation via a tight branch loop
        do_reset();
        go(1);
        branch_taken = 1; branch_target = 32'h0;
        chk_en = 0;
        repeat (70000) tick();
        chk_en = 1;
        chk("t7_sat", 32'(retired), 32'hFFFF);
        branch_taken = 0;
        tick();

        // Random episodes
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++) begin
                logic [31:0] d;
                d = $urandom;
                if (d == HW) d = 0;
                if ($urandom_range(0, 5) == 0) d = HW;
                load(i, d);
            end
            go(1'($urandom_range(0, 1)));
            for (int c = 0; c < 80; c++) begin
                stall         = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 2) == 0) step = ~step;
                branch_taken  = ($urandom_range(0, 4) == 0);
                branch_target = 32'($urandom_range(0, 32'h48));
                start         = ($urandom_range(0, 19) == 0);
                run           = 1'($urandom_range(0, 1));
                prog_we       = ($urandom_range(0, 9) == 0);
                prog_addr     = 4'($urandom_range(0, 15));
                prog_data     = $urandom;
                tick();
            end
            start = 0; prog_we = 0; stall = 0; branch_taken = 0; step = 0;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
